// File: rtl/seg7_scan_decode_if.sv
// Bundle of the scanned display lines being observed and the decoded
// results produced from them.
interface seg7_scan_decode_if;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        clr_err;
  logic [15:0] value;
  logic [3:0]  digit_valid;
  logic [3:0]  blank;
  logic        err;
  logic        frame_done;

  modport master (
    output an, seg, clr_err,
    input  value, digit_valid, blank, err, frame_done
  );

  modport slave (
    input  an, seg, clr_err,
    output value, digit_valid, blank, err, frame_done
  );
endinterface

// File: rtl/seg7_scan_decode.sv
// Snoops a multiplexed 4-digit active-low 7-segment display and recovers
// the hex digits shown. A digit is captured only after {an,seg} has been
// identical for STABLE_CYCLES consecutive samples with exactly one an low.
module seg7_scan_decode #(
  parameter int STABLE_CYCLES = 4
) (
  input logic               clk,
  input logic               rst_n,
  seg7_scan_decode_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

  // Returns {legal, blank, nibble} for an active-low {g..a} pattern.
  function automatic logic [5:0] decode_seg(input logic [6:0] s);
    logic [5:0] r;
    case (s)
      7'b1000000: r = {2'b10, 4'h0};
      7'b1111001: r = {2'b10, 4'h1};
      7'b0100100: r = {2'b10, 4'h2};
      7'b0110000: r = {2'b10, 4'h3};
      7'b0011001: r = {2'b10, 4'h4};
      7'b0010010: r = {2'b10, 4'h5};
      7'b0000010: r = {2'b10, 4'h6};
      7'b1111000: r = {2'b10, 4'h7};
      7'b0000000: r = {2'b10, 4'h8};
      7'b0011000: r = {2'b10, 4'h9};
      7'b0001000: r = {2'b10, 4'hA};
      7'b0000011: r = {2'b10, 4'hB};
      7'b1000110: r = {2'b10, 4'hC};
      7'b0100001: r = {2'b10, 4'hD};
      7'b0000110: r = {2'b10, 4'hE};
      7'b0001110: r = {2'b10, 4'hF};
      7'b1111111: r = {2'b01, 4'h0};
      default:    r = {2'b00, 4'h0};
    endcase
    return r;
  endfunction

  // Returns {one_hot_low, digit_index} for the digit-enable lines.
  function automatic logic [2:0] decode_an(input logic [3:0] a);
    logic [2:0] r;
    case (a)
      4'b1110: r = {1'b1, 2'd0};
      4'b1101: r = {1'b1, 2'd1};
      4'b1011: r = {1'b1, 2'd2};
      4'b0111: r = {1'b1, 2'd3};
      default: r = {1'b0, 2'd0};
    endcase
    return r;
  endfunction

  state_t      state_r;
  logic [7:0]  cnt_r;
  logic [10:0] samp_r;
  logic [3:0]  mask_r;
  logic [15:0] value_r;
  logic [3:0]  valid_r;
  logic [3:0]  blank_r;
  logic        err_r;
  logic        frame_done_r;

  logic [10:0] in_s;
  logic        changed_s;
  logic [2:0]  an_dec_s;
  logic        onehot_s;
  logic [1:0]  sel_s;
  logic [5:0]  seg_dec_s;
  logic        cap_s;
  logic [3:0]  cap_mask_s;

  assign in_s      = {bus.an, bus.seg};
  assign changed_s = (in_s != samp_r);
  assign an_dec_s  = decode_an(bus.an);
  assign onehot_s  = an_dec_s[2];
  assign sel_s     = an_dec_s[1:0];
  assign seg_dec_s = decode_seg(bus.seg);

  // Decide whether this edge is a capture edge and which digit it hits.
  always_comb begin
    cap_s      = 1'b0;
    cap_mask_s = 4'b0000;
    case (state_r)
      IDLE:    cap_s = onehot_s && (STABLE_C == 8'd1);
      SETTLE:  cap_s = !changed_s && ((cnt_r + 8'd1) == STABLE_C);
      HOLD:    cap_s = 1'b0;
      default: cap_s = 1'b0;
    endcase
    if (cap_s) begin
      cap_mask_s = 4'b0001 << sel_s;
    end else begin
      cap_mask_s = 4'b0000;
    end
  end

  // Stability FSM plus all registered decode outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= 8'd0;
      samp_r       <= 11'h7FF;
      mask_r       <= 4'b0000;
      value_r      <= 16'h0000;
      valid_r      <= 4'b0000;
      blank_r      <= 4'b0000;
      err_r        <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      samp_r <= in_s;

      case (state_r)
        IDLE: begin
          if (onehot_s) begin
            cnt_r   <= 8'd1;
            state_r <= cap_s ? HOLD : SETTLE;
          end else begin
            cnt_r   <= 8'd0;
            state_r <= IDLE;
          end
        end
        SETTLE, HOLD: begin
          if (changed_s) begin
            // Any change restarts qualification; never a capture edge.
            if (onehot_s) begin
              cnt_r   <= 8'd1;
              state_r <= SETTLE;
            end else begin
              cnt_r   <= 8'd0;
              state_r <= IDLE;
            end
          end else if (state_r == SETTLE) begin
            cnt_r   <= cnt_r + 8'd1;
            state_r <= cap_s ? HOLD : SETTLE;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          cnt_r   <= 8'd0;
          state_r <= IDLE;
        end
      endcase

      if (cap_s) begin
        if (seg_dec_s[5]) begin
          value_r[sel_s*4 +: 4] <= seg_dec_s[3:0];
          valid_r[sel_s]        <= 1'b1;
          blank_r[sel_s]        <= 1'b0;
        end else if (seg_dec_s[4]) begin
          valid_r[sel_s]        <= 1'b0;
          blank_r[sel_s]        <= 1'b1;
        end else begin
          valid_r[sel_s]        <= 1'b0;
          blank_r[sel_s]        <= 1'b0;
        end
      end else begin
        value_r <= value_r;
      end

      // Illegal capture wins over a simultaneous clear.
      if (cap_s && !seg_dec_s[5] && !seg_dec_s[4]) begin
        err_r <= 1'b1;
      end else if (bus.clr_err) begin
        err_r <= 1'b0;
      end else begin
        err_r <= err_r;
      end

      // A full mask is reported and restarted; a capture on the same edge
      // seeds the next frame.
      if (mask_r == 4'b1111) begin
        frame_done_r <= 1'b1;
        mask_r       <= cap_mask_s;
      end else begin
        frame_done_r <= 1'b0;
        mask_r       <= mask_r | cap_mask_s;
      end
    end
  end

  assign bus.value       = value_r;
  assign bus.digit_valid = valid_r;
  assign bus.blank       = blank_r;
  assign bus.err         = err_r;
  assign bus.frame_done  = frame_done_r;

endmodule

// File: tb/tb_seg7_scan_decode.sv
// Directed, table-driven bench for seg7_scan_decode (default STABLE_CYCLES).
module tb_seg7_scan_decode;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vec_cnt = 0;
  int   miss_cnt = 0;
  int   fd_cnt = 0;

  seg7_scan_decode_if bus ();

  seg7_scan_decode #(.STABLE_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Count frame_done pulses; each high cycle is seen at exactly one edge.
  always @(posedge clk) begin
    if (bus.frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
  end

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    int          hold;
    logic [15:0] value;
    logic [3:0]  dv;
    logic [3:0]  blk;
    logic        err;
    int          fd;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input logic [3:0] an, input logic [6:0] seg, input int n);
    bus.an  = an;
    bus.seg = seg;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_all(input string tag, input logic [15:0] v, input logic [3:0] dv,
                         input logic [3:0] blk, input logic e, input int fd);
    chk({tag, " value"}, bus.value, v);
    chk({tag, " digit_valid"}, {12'h000, bus.digit_valid}, {12'h000, dv});
    chk({tag, " blank"}, {12'h000, bus.blank}, {12'h000, blk});
    chk({tag, " err"}, {15'h0000, bus.err}, {15'h0000, e});
    chk({tag, " frame_count"}, 16'(fd_cnt), 16'(fd));
  endtask

  initial begin
    // an, seg, hold, value, dv, blank, err, frames
    vecs[0]  = '{4'b0111, 7'b1111001, 6, 16'h1000, 4'h8, 4'h0, 1'b0, 0};
    vecs[1]  = '{4'b1011, 7'b0100100, 6, 16'h1200, 4'hC, 4'h0, 1'b0, 0};
    vecs[2]  = '{4'b1101, 7'b0110000, 6, 16'h1230, 4'hE, 4'h0, 1'b0, 0};
    vecs[3]  = '{4'b1110, 7'b0011001, 6, 16'h1234, 4'hF, 4'h0, 1'b0, 1};
    vecs[4]  = '{4'b1100, 7'b0000000, 20, 16'h1234, 4'hF, 4'h0, 1'b0, 1};
    vecs[5]  = '{4'b1111, 7'b0000000, 20, 16'h1234, 4'hF, 4'h0, 1'b0, 1};
    vecs[6]  = '{4'b1110, 7'b0001000, 3, 16'h1234, 4'hF, 4'h0, 1'b0, 1};
    vecs[7]  = '{4'b1110, 7'b1000110, 4, 16'h123C, 4'hF, 4'h0, 1'b0, 1};
    vecs[8]  = '{4'b1011, 7'b1111111, 4, 16'h123C, 4'hB, 4'h4, 1'b0, 1};
    vecs[9]  = '{4'b1101, 7'b0000011, 4, 16'h12BC, 4'hB, 4'h4, 1'b0, 1};
    vecs[10] = '{4'b1110, 7'b0010010, 6, 16'h12B5, 4'hB, 4'h4, 1'b0, 1};
    vecs[11] = '{4'b0111, 7'b0000110, 6, 16'hE2B5, 4'hB, 4'h4, 1'b0, 2};

    bus.an      = 4'b1111;
    bus.seg     = 7'b1111111;
    bus.clr_err = 1'b0;
    repeat (3) @(negedge clk);
    chk_all("reset", 16'h0000, 4'h0, 4'h0, 1'b0, 0);
    chk("reset frame_done", {15'h0000, bus.frame_done}, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      apply(vecs[i].an, vecs[i].seg, vecs[i].hold);
      chk_all($sformatf("vec%0d", i), vecs[i].value, vecs[i].dv, vecs[i].blk,
              vecs[i].err, vecs[i].fd);
    end

    // Illegal capture on the same edge as clr_err: set wins.
    apply(4'b1101, 7'b1010101, 3);
    chk("pre-illegal err", {15'h0000, bus.err}, 16'h0000);
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
    chk_all("illegal+clr", 16'hE2B5, 4'h9, 4'h4, 1'b1, 2);
    apply(4'b1101, 7'b1010101, 2);
    chk("err sticky", {15'h0000, bus.err}, 16'h0001);
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
    chk("clr alone", {15'h0000, bus.err}, 16'h0000);

    // Reset mid-frame and mid-settle discards count and mask.
    rst_n = 1'b0;
    @(negedge clk);
    chk_all("reset2", 16'h0000, 4'h0, 4'h0, 1'b0, 2);
    rst_n = 1'b1;
    apply(4'b1110, 7'b1111000, 6);
    apply(4'b1101, 7'b0000000, 6);
    apply(4'b1011, 7'b0011000, 6);
    chk_all("three digits", 16'h0987, 4'h7, 4'h0, 1'b0, 2);
    apply(4'b0111, 7'b0001110, 2);
    rst_n = 1'b0;
    @(negedge clk);
    chk_all("reset3", 16'h0000, 4'h0, 4'h0, 1'b0, 2);
    rst_n = 1'b1;
    apply(4'b0111, 7'b0001110, 3);
    chk("post-reset 3 edges dv", {12'h000, bus.digit_valid}, 16'h0000);
    apply(4'b0111, 7'b0001110, 1);
    chk_all("post-reset capture", 16'hF000, 4'h8, 4'h0, 1'b0, 2);
    apply(4'b0111, 7'b0001110, 4);
    chk("no frame after reset", 16'(fd_cnt), 16'd2);
    apply(4'b1110, 7'b1111000, 6);
    apply(4'b1101, 7'b0000000, 6);
    apply(4'b1011, 7'b0011000, 6);
    chk_all("frame after reset", 16'hF987, 4'hF, 4'h0, 1'b0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
